// File: rtl/poc_chain_bist_if.sv
// Bus bundle between the chain BIST driver and its environment.
// slave = BIST driver side, master = environment/test side.
interface poc_chain_bist_if;
  logic        start_i;
  logic        y_i;
  logic [5:0]  a_o;
  logic [5:0]  b_o;
  logic        busy_o;
  logic        done_o;
  logic        pass_o;
  logic [15:0] sig_o;

  modport slave (
    input  start_i,
    input  y_i,
    output a_o,
    output b_o,
    output busy_o,
    output done_o,
    output pass_o,
    output sig_o
  );

  modport master (
    output start_i,
    output y_i,
    input  a_o,
    input  b_o,
    input  busy_o,
    input  done_o,
    input  pass_o,
    input  sig_o
  );
endinterface

// File: rtl/poc_chain_bist.sv
// LFSR pattern driver and MISR compactor for the AND/OR carry chain.
// Optional golden compare enabled by POC_BIST_GOLDEN_CHECK_EN.
module poc_chain_bist #(
  parameter int unsigned NUM_PATTERNS = 256,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter logic [11:0] LFSR_SEED    = 12'hACE,
  parameter logic [15:0] GOLDEN_SIG   = 16'h0000
) (
  input  logic            clk,
  input  logic            rst,
  poc_chain_bist_if.slave bus
);

  localparam logic [15:0] RUN_LAST   = 16'(NUM_PATTERNS - 1);
  localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_CYCLES - 1);
  localparam logic [15:0] MISR_INIT  = 16'hFFFF;
  localparam logic [15:0] MISR_POLY  = 16'h1021;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [11:0] lfsr;
  logic [11:0] lfsr_next;
  logic [15:0] cnt;
  logic [15:0] sig;
  logic [15:0] sig_next;
  logic [5:0]  a;
  logic [5:0]  b;
  logic        run_last;
  logic        drain_last;
  logic        launch;

  assign lfsr_next = {lfsr[10:0],
                      lfsr[11] ^ lfsr[5] ^ lfsr[3] ^ lfsr[0]};

  assign sig_next = {sig[14:0], 1'b0}
                  ^ (sig[15] ? MISR_POLY : 16'h0000)
                  ^ {15'b0, bus.y_i};

  assign run_last   = (cnt == RUN_LAST);
  assign drain_last = (cnt == DRAIN_LAST);

  // Start is only accepted when no run is in flight.
  assign launch = bus.start_i &&
                  ((state_q == IDLE) || (state_q == DONE));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (launch)     state_d = RUN;
      RUN:   if (run_last)   state_d = DRAIN;
      DRAIN: if (drain_last) state_d = DONE;
      DONE:  if (launch)     state_d = RUN;
    endcase
  end

  // Pattern generation, phase counting and signature compaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= LFSR_SEED;
      cnt  <= '0;
      sig  <= MISR_INIT;
      a    <= '0;
      b    <= '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (launch) begin
            lfsr <= LFSR_SEED;
            cnt  <= '0;
            sig  <= MISR_INIT;
            a    <= LFSR_SEED[11:6];
            b    <= LFSR_SEED[5:0];
          end
        end
        RUN: begin
          lfsr <= lfsr_next;
          sig  <= sig_next;
          if (run_last) begin
            cnt <= '0;
            a   <= '0;
            b   <= '0;
          end else begin
            cnt <= cnt + 16'd1;
            a   <= lfsr_next[11:6];
            b   <= lfsr_next[5:0];
          end
        end
        DRAIN: begin
          sig <= sig_next;
          cnt <= cnt + 16'd1;
        end
      endcase
    end
  end

`ifdef POC_BIST_GOLDEN_CHECK_EN
  logic pass_q;

  // Compare the final signature (including the last drain sample).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_q <= 1'b0;
    end else if (launch) begin
      pass_q <= 1'b0;
    end else if ((state_q == DRAIN) && drain_last) begin
      pass_q <= (sig_next == GOLDEN_SIG);
    end
  end

  assign bus.pass_o = pass_q;
`else
  logic unused_golden;

  assign unused_golden = ^GOLDEN_SIG;
  assign bus.pass_o    = 1'b0;
`endif

  assign bus.a_o    = a;
  assign bus.b_o    = b;
  assign bus.busy_o = (state_q == RUN) || (state_q == DRAIN);
  assign bus.done_o = (state_q == DONE);
  assign bus.sig_o  = sig;

endmodule

// File: tb/tb_poc_chain_bist.sv
// Directed bench for poc_chain_bist with a signature scoreboard.
// Uses NUM_PATTERNS=4, DRAIN_CYCLES=4, golden 16'hE1F0.
module tb_poc_chain_bist;

  localparam int NP = 4;
  localparam int ND = 4;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  logic [15:0] exp_sig_q[$];
  logic        exp_pass_q[$];

  poc_chain_bist_if bus ();

  poc_chain_bist #(
    .NUM_PATTERNS (NP),
    .DRAIN_CYCLES (ND),
    .LFSR_SEED    (12'hACE),
    .GOLDEN_SIG   (16'hE1F0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] misr_step(
    input logic [15:0] s,
    input logic        y
  );
    logic [15:0] r;
    r = {s[14:0], 1'b0};
    if (s[15]) r = r ^ 16'h1021;
    r[0] = r[0] ^ y;
    return r;
  endfunction

  task automatic check(
    input string       tag,
    input logic [15:0] obs,
    input logic [15:0] exp
  );
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_a"},    {10'b0, bus.a_o}, 16'h0);
    check({tag, "_b"},    {10'b0, bus.b_o}, 16'h0);
    check({tag, "_busy"}, {15'b0, bus.busy_o}, 16'h0);
    check({tag, "_done"}, {15'b0, bus.done_o}, 16'h0);
    check({tag, "_pass"}, {15'b0, bus.pass_o}, 16'h0);
    check({tag, "_sig"},  bus.sig_o, 16'hFFFF);
  endtask

  // Called at a negedge with the DUT in IDLE or DONE.
  task automatic run_bist(
    input string      tag,
    input logic [7:0] ymask,
    input bit         poke
  );
    logic [15:0] s;
    logic        p;
    logic [15:0] got;
    s = 16'hFFFF;
    for (int k = 0; k < NP + ND; k++) s = misr_step(s, ymask[k]);
`ifdef POC_BIST_GOLDEN_CHECK_EN
    p = (s == 16'hE1F0);
`else
    p = 1'b0;
`endif
    exp_sig_q.push_back(s);
    exp_pass_q.push_back(p);

    bus.start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start_i = 1'b0;
    check({tag, "_a0"},    {10'b0, bus.a_o}, 16'h002B);
    check({tag, "_b0"},    {10'b0, bus.b_o}, 16'h000E);
    check({tag, "_busy0"}, {15'b0, bus.busy_o}, 16'h1);
    check({tag, "_done0"}, {15'b0, bus.done_o}, 16'h0);

    for (int k = 1; k <= NP + ND; k++) begin
      bus.y_i     = ymask[k-1];
      bus.start_i = poke && (k == 3 || k == 6);
      @(posedge clk);
      @(negedge clk);
      if (k == 1) begin
        check({tag, "_a1"},    {10'b0, bus.a_o}, 16'h0016);
        check({tag, "_b1"},    {10'b0, bus.b_o}, 16'h001C);
        check({tag, "_busy1"}, {15'b0, bus.busy_o}, 16'h1);
      end
      if (k == NP + 1) begin
        check({tag, "_a_drain"}, {10'b0, bus.a_o}, 16'h0);
        check({tag, "_b_drain"}, {10'b0, bus.b_o}, 16'h0);
      end
      check({tag, "_done_t"}, {15'b0, bus.done_o},
            {15'b0, (k == NP + ND)});
    end
    bus.y_i     = 1'b0;
    bus.start_i = 1'b0;

    check({tag, "_busy_end"}, {15'b0, bus.busy_o}, 16'h0);
    got = exp_sig_q.pop_front();
    check({tag, "_sig"}, bus.sig_o, got);
    check({tag, "_pass"}, {15'b0, bus.pass_o},
          {15'b0, exp_pass_q.pop_front()});

    @(negedge clk);
    check({tag, "_sig_hold"}, bus.sig_o, got);
    check({tag, "_done_hold"}, {15'b0, bus.done_o}, 16'h1);
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    rst         = 1'b1;
    bus.start_i = 1'b0;
    bus.y_i     = 1'b0;
    #1;
    check_reset("por");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset("idle");

    run_bist("zero", 8'h00, 1'b1);
    check("zero_sig_const", bus.sig_o, 16'hE1F0);

    run_bist("rerun", 8'h00, 1'b0);
    check("rerun_sig_const", bus.sig_o, 16'hE1F0);

    run_bist("err", 8'h20, 1'b0);
    total++;
    assert (bus.sig_o !== 16'hE1F0)
    else begin
      bad++;
      $error("FAIL err_sig_differs observed=%0h expected!=e1f0",
             bus.sig_o);
    end

    bus.start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start_i = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_reset("midrun");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset("midrun_idle");
    run_bist("after_rst", 8'h00, 1'b0);
    check("after_rst_sig_const", bus.sig_o, 16'hE1F0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/poc_chain_bist.md
# poc_chain_bist

Built-in self-test driver for the proof-of-concept AND/OR carry-chain design under OpenROAD flow. It generates pseudo-random 6-bit propagate (`a`) and generate (`b`) vectors from an LFSR and drives them into the chain's inputs. It compacts the chain's `y` output into a 16-bit MISR signature. The chain can then be exercised and checked on silicon or in gate-level simulation without external vectors.

## Interface
- `NUM_PATTERNS`, 256: RUN-phase cycles (1..65535).
- `DRAIN_CYCLES`, 4: post-pattern cycles still compacted (1..255); covers chain pipeline and feedback flops.
- `LFSR_SEED`, 12'hACE: LFSR load value; must be nonzero.
- `GOLDEN_SIG`, 16'h0000: expected final signature (used only with the check feature).
- `clk` input 1: single clock. All state changes on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start_i` input 1: one-cycle start request; honoured in IDLE and DONE only.
- `y_i` input 1: chain output under test.
- `a_o` output 6: propagate vector to the chain, registered.
- `b_o` output 6: generate vector to the chain, registered.
- `busy_o` output 1: high in RUN and DRAIN.
- `done_o` output 1: high in DONE.
- `pass_o` output 1: signature compare result, valid while `done_o`.
- `sig_o` output 16: live MISR register.

## Operation
- FSM states are IDLE, RUN, DRAIN and DONE. Reset enters IDLE.
- **IDLE/DONE + `start_i`:** go to RUN. On that edge:
  - LFSR ← `LFSR_SEED`.
  - MISR ← 16'hFFFF.
  - Pattern counter ← 0.
  - `{a_o,b_o}` ← `LFSR_SEED`.
- **RUN:**
  - `a_o` = lfsr[11:6] and `b_o` = lfsr[5:0] on every cycle.
  - The LFSR advances every cycle.
  - After `NUM_PATTERNS` RUN cycles, go to DRAIN. On that edge, `a_o`/`b_o` ← 0.
- **DRAIN:**
  - `a_o`/`b_o` hold 0.
  - After `DRAIN_CYCLES` cycles, go to DONE.
- **DONE:** `sig_o` and `pass_o` hold until the next start or reset.
- **LFSR:** 12-bit Fibonacci, polynomial x^12+x^6+x^4+x+1.
  - next = {l[10:0], l[11]^l[5]^l[3]^l[0]}.
  - Period 4095. The all-zero state is unreachable from a nonzero seed.
- **MISR:** updated on every edge where state is RUN or DRAIN (`NUM_PATTERNS`+`DRAIN_CYCLES` samples total).
  - sig_next = {sig[14:0],1'b0} ^ (sig[15] ? 16'h1021 : 0) ^ {15'b0, y_i}.
- `start_i` in RUN or DRAIN is ignored. There is no restart and no abort.
- **Reset mid-operation:** immediately returns all state and outputs to reset values, with no completion reported.

## Timing
- **Reset values:**
  - `a_o`=0, `b_o`=0.
  - `busy_o`=0, `done_o`=0, `pass_o`=0.
  - `sig_o`=16'hFFFF.
  - LFSR=`LFSR_SEED`, counter=0.
- **From a `start_i` sampled at edge T:**
  - `busy_o`=1 and `a_o`/`b_o`=seed from T+1.
  - The last pattern is visible in cycle T+`NUM_PATTERNS`.
  - `done_o`=1 from T+1+`NUM_PATTERNS`+`DRAIN_CYCLES`.
- **`done_o` and `pass_o`:** both update on the same edge. `done_o` drops on the edge that leaves DONE.
- **`y_i`:** treated as synchronous to `clk`; the sample is taken at each edge.

## Configuration
- Macro: `POC_BIST_GOLDEN_CHECK_EN`.
- **Defined:** on entry to DONE, `pass_o` ← (MISR == `GOLDEN_SIG`).
- **Undefined:**
  - The comparator and `GOLDEN_SIG` use are removed.
  - `pass_o` is tied 0.
  - The result is read from `sig_o` only.

## Test plan
- **Reset values:** assert `rst` asynchronously mid-cycle. Expect immediately `a_o`=0, `b_o`=0, `busy_o`=0, `done_o`=0, `pass_o`=0, `sig_o`=16'hFFFF.
- **Pattern sequence:** default seed, start. Expect:
  - First RUN cycle: `a_o`=6'h2B, `b_o`=6'h0E.
  - Second RUN cycle: `a_o`=6'h16, `b_o`=6'h1C.
  - `busy_o`=1 through both.
- **Zero-input signature:** `NUM_PATTERNS`=4, `DRAIN_CYCLES`=4, `y_i` tied 0. Expect:
  - `done_o` rises at T+9.
  - `sig_o`=16'hE1F0.
  - With the macro and `GOLDEN_SIG`=16'hE1F0, `pass_o`=1.
- **Error detection:** same as the zero-input signature case but force `y_i`=1 for one DRAIN cycle. Expect `sig_o`≠16'hE1F0 and `pass_o`=0. Without the macro, `pass_o`=0 in both cases.
- **Start during a run:** pulse `start_i` during RUN and again during DRAIN. Expect no effect; `done_o` timing is unchanged. A start in DONE re-runs and reproduces the identical signature.
- **Reset mid-RUN:** assert reset mid-RUN, then start again. Expect a full-length run, the same signature as an uninterrupted run, and no earlier `done_o`.
